// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset main control unit.
// Steps each instruction through fetch, decode, execute, memory and writeback,
// driving the ALU datapath selects plus the PC/IR/register-file/memory enables.
//
// The PC increment is one word (ADDR_INC = 1), so FETCH selects the constant-1
// ALU operand. This is fixed and therefore not a parameter.
//
// Build option MC_CTRL_MEM_HANDSHAKE_EN:
//   defined   - FETCH, MEM_RD and MEM_WR wait for mem_ready_i.
//   undefined - mem_ready_i is ignored and treated as 1, so each of those
//               states lasts exactly one cycle.
//
// state    | meaning
// ---------+-------------------------------------------------
// INIT     | reset state, all outputs 0
// FETCH    | read instruction at PC, PC <= PC + 1
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | lw/sw effective address
// MEM_RD   | data read, held until memory completes
// MEM_WB   | MDR -> rt
// MEM_WR   | data write, held until memory completes
// R_EXEC   | R-type ALU operation chosen by funct
// R_WB     | ALUOut -> rd
// BRANCH   | beq/bne compare, conditional PC load
// JUMP     | PC <= jump target
// I_EXEC   | addi ALU operation
// I_WB     | ALUOut -> rt
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       alu_srcA_o,
  output logic [1:0] alu_srcB_o,
  output logic [2:0] alu_ctrl_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_op_o,
  output logic [3:0] state_dbg_o
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOR = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Outputs that depend on the state alone; these come straight from flops.
  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } moore_t;

  state_e     state_q, state_d;
  moore_t     mo_q;
  logic       mem_ready_eff;
  logic       op_legal;
  logic       funct_legal;
  logic [2:0] funct_alu;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
  assign mem_ready_eff = mem_ready_i;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready_i;
  assign mem_ready_eff    = 1'b1;
`endif

  // Moore output table, evaluated on the next state so outputs are registered.
  function automatic moore_t decode_moore(input state_e s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_read  = 1'b1;
        m.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        m.alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        m.iord     = 1'b1;
        m.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        m.reg_write  = 1'b1;
        m.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        m.iord      = 1'b1;
        m.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        m.alu_src_a = 1'b1;
      end
      S_R_WB: begin
        m.reg_write = 1'b1;
        m.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        m.alu_src_a = 1'b1;
        m.alu_ctrl  = ALU_SUB;
        m.pc_src    = 2'b01;
      end
      S_JUMP: begin
        m.pc_src   = 2'b10;
        m.pc_write = 1'b1;
      end
      S_I_EXEC: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'b10;
      end
      S_I_WB: begin
        m.reg_write = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Opcode legality for the DECODE dispatch.
  always_comb begin
    op_legal = 1'b0;
    case (opcode_i)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // R-type funct to ALU operation; unsupported funct leaves the ALU at 000.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct_i)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100111: funct_alu = ALU_NOR;
      6'b100100: funct_alu = ALU_AND;
      6'b101010: funct_alu = ALU_SLT;
      default: begin
        funct_legal = 1'b0;
        funct_alu   = ALU_ADD;
      end
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready_eff) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_I_EXEC;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_eff) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready_eff) state_d = S_FETCH;
      S_R_EXEC:   state_d = funct_legal ? S_R_WB : S_FETCH;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State and registered Moore outputs; reset clears both at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      mo_q    <= '0;
    end else begin
      state_q <= state_d;
      mo_q    <= decode_moore(state_d);
    end
  end

  // Input-dependent outputs, each qualified by the registered state so that
  // reset silences them without waiting for a clock edge.
  always_comb begin
    alu_ctrl_o   = mo_q.alu_ctrl;
    pc_write_o   = mo_q.pc_write;
    ir_write_o   = 1'b0;
    illegal_op_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_write_o = mem_ready_eff;
        ir_write_o = mem_ready_eff;
      end
      S_DECODE: illegal_op_o = ~op_legal;
      S_R_EXEC: begin
        alu_ctrl_o   = funct_alu;
        illegal_op_o = ~funct_legal;
      end
      S_BRANCH: begin
        if (opcode_i == OP_BEQ)      pc_write_o = zero_i;
        else if (opcode_i == OP_BNE) pc_write_o = ~zero_i;
        else                         pc_write_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign alu_srcA_o   = mo_q.alu_src_a;
  assign alu_srcB_o   = mo_q.alu_src_b;
  assign pc_src_o     = mo_q.pc_src;
  assign iord_o       = mo_q.iord;
  assign mem_read_o   = mo_q.mem_read;
  assign mem_write_o  = mo_q.mem_write;
  assign reg_write_o  = mo_q.reg_write;
  assign reg_dst_o    = mo_q.reg_dst;
  assign mem_to_reg_o = mo_q.mem_to_reg;
  assign state_dbg_o  = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS-subset main control unit. It is the driving end of the ALU datapath interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives ALU operand selects, ALU operation, PC/IR/register-file/memory enables, and resolves branches from the ALU zero flag.

Parameters:
- ADDR_INC, 1, PC increment is one word (selects constant-1 operand); fixed, documented only.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current access this cycle
- alu_srcA  out  1  0=PC, 1=register A
- alu_srcB  out  2  00=reg B, 01=const 1, 10=sign-ext imm, 11=shifted imm
- alu_ctrl  out  3  000 add, 001 sub, 010 nor, 011 and, 111 slt
- pc_write  out  1  load PC
- pc_src  out  2  00 ALU result, 01 ALUOut reg, 10 jump target {pc[31:26],instr[25:0]}
- iord  out  1  0=instruction addr (PC), 1=data addr (ALUOut)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_write  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
- state_dbg  out  4  current state encoding

Behaviour:
- States (4-bit): INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
- Reset: rst_n low asynchronously forces INIT. In INIT every output is 0; state_dbg=0. First clock after release goes INIT->FETCH.
- Outputs are Moore-decoded from state. Exceptions: pc_write in BRANCH depends on zero; pc_write/ir_write in FETCH depend on mem_ready. Unlisted outputs are 0.
- FETCH:
  - iord=0, mem_read=1, alu_srcA=0, alu_srcB=01, alu_ctrl=000, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Go to DECODE when mem_ready=1, else hold.
- DECODE:
  - alu_srcA=0, alu_srcB=11, alu_ctrl=000 (branch target into ALUOut).
  - Dispatch:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 -> R_EXEC
    - 000100 (beq) or 000101 (bne) -> BRANCH
    - 001000 (addi) -> I_EXEC
    - 000010 (j) -> JUMP
    - else -> FETCH, with illegal_op=1 for that cycle
- MEM_ADDR: alu_srcA=1, alu_srcB=10, alu_ctrl=000. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEM_WR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- R_EXEC:
  - alu_srcA=1, alu_srcB=00.
  - alu_ctrl from funct: 100000->000, 100010->001, 100111->010, 100100->011, 101010->111.
  - Any other funct: illegal_op=1, next FETCH, no writeback. Otherwise next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH:
  - alu_srcA=1, alu_srcB=00, alu_ctrl=001, pc_src=01.
  - pc_write = zero for beq, ~zero for bne. Then FETCH.
- JUMP: pc_src=10, pc_write=1. Then FETCH.
- I_EXEC: alu_srcA=1, alu_srcB=10, alu_ctrl=000. Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- Cycle counts with zero-wait memory:
  - lw 5; sw, R-type, addi 4; beq, bne, j 3; illegal 2.
- Each memory wait cycle adds 1. mem_read/mem_write stay high for the whole wait.
- mem_write and mem_read are never high together. reg_write is never high in the same cycle as pc_write.
- Reset asserted mid-instruction aborts it immediately; no partial write is issued after reset.
- Unused encodings 13-15 go to FETCH on the next clock, with all outputs 0 in that cycle.

Optional Feature:
- MC_CTRL_MEM_HANDSHAKE_EN.
- Defined: mem_ready handshake exactly as above.
- Undefined: mem_ready is ignored and treated as 1. Every FETCH, MEM_RD and MEM_WR lasts exactly one cycle.

Test Plan:
- Reset, release rst_n, mem_ready=1 -> state_dbg 0->1. FETCH shows mem_read=1, alu_srcB=01, pc_write=1, ir_write=1.
- R-type opcode=000000, funct=101010, mem_ready=1 -> states 1,2,7,8,1. alu_ctrl=111 in R_EXEC; reg_write=1, reg_dst=1 in R_WB.
- lw (100011), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles with iord=1, mem_read=1. Then MEM_WB with mem_to_reg=1. Total 7 cycles.
- beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH. bne with zero=1 -> pc_write=0.
- opcode=111111 -> illegal_op pulses in DECODE, next state FETCH. R-type funct=000001 -> illegal_op in R_EXEC, reg_write never asserted.
- rst_n dropped during MEM_WR -> state_dbg=0 and mem_write=0 immediately, without waiting for a clock edge.
